gt_rx_link_aligner: RTL

//  RX-side link bring-up and word alignment for one GT receive lane (20-bit raw, no 8b/10b).
//  - Synchronises GT rxresetdone into a fabric reset.
//  - Hunts for a fixed header in every received word, issuing single-cycle RXSLIP requests.
//  - Declares/drops link lock and counts header errors.

---
 rtl/gt_rx_link_aligner_if.sv | 24 ++
 rtl/gt_rx_link_aligner.sv | 113 +++++++++++
 2 files changed

// File: rtl/gt_rx_link_aligner_if.sv
// gt_rx_link_aligner_if: RX lane data, control and status bundle between the GT wrapper side and gt_rx_link_aligner.
interface gt_rx_link_aligner_if #(
  parameter int DATA_W = 20,
  parameter int ERR_W = 16
);
  logic [DATA_W-1:0] rx_data_in;
  logic clear_err;
  logic rx_system_reset;
  logic rx_slip;
  logic rx_polarity;
  logic link_up;
  logic [DATA_W-1:0] rx_data_out;
  logic rx_data_valid;
  logic [4:0] slip_count;
  logic [ERR_W-1:0] err_count;
  modport master (
    output rx_data_in, clear_err,
    input rx_system_reset, rx_slip, rx_polarity, link_up, rx_data_out, rx_data_valid, slip_count, err_count
  );
  modport slave (
    input rx_data_in, clear_err,
    output rx_system_reset, rx_slip, rx_polarity, link_up, rx_data_out, rx_data_valid, slip_count, err_count
  );
endinterface

// File: rtl/gt_rx_link_aligner.sv
// gt_rx_link_aligner: GT RX reset sync, header hunt with RXSLIP, lock tracking and error count.
// Define GT_RX_AUTO_POLARITY_EN to let an inverted header toggle rx_polarity while hunting.
module gt_rx_link_aligner #(
  parameter int DATA_W = 20,
  parameter int HDR_W = 4,
  parameter logic [HDR_W-1:0] HDR_PATTERN = 4'hA,
  parameter int SYNC_STAGES = 3,
  parameter int HUNT_WORDS = 64,
  parameter int SLIP_WAIT = 32,
  parameter int LOCK_CNT = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int ERR_W = 16
) (
  input logic gt0_rxusrclk2_out,
  input logic gt0_rxresetdone_out,
  gt_rx_link_aligner_if.slave lnk
);
  typedef enum logic [2:0] {WAIT, HUNT, SLIP, VERIFY, LOCKED} state_t;
  localparam int WC_W = $clog2(HUNT_WORDS);
  localparam int SW_W = $clog2(SLIP_WAIT);
  localparam int MC_W = $clog2(LOCK_CNT);
  localparam int UC_W = $clog2(UNLOCK_CNT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(HUNT_WORDS - 1);
  localparam logic [SW_W-1:0] SW_LAST = SW_W'(SLIP_WAIT - 1);
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(LOCK_CNT - 1);
  localparam logic [UC_W-1:0] UC_LAST = UC_W'(UNLOCK_CNT - 1);
  localparam logic [4:0] SC_LAST = 5'(DATA_W - 1);
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
  state_t state, state_nxt;
  logic [WC_W-1:0] word_cnt, word_cnt_nxt;
  logic [SW_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [MC_W-1:0] match_cnt, match_cnt_nxt;
  logic [UC_W-1:0] miss_cnt, miss_cnt_nxt;
  logic [HDR_W-1:0] hdr;
  logic hdr_ok, hdr_inv, slip_nxt, pol_flip, lock_nxt, err_inc, pol_q;
  always_ff @(posedge gt0_rxusrclk2_out or negedge gt0_rxresetdone_out)
    if (!gt0_rxresetdone_out) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  assign lnk.rx_system_reset = ~sync_q[SYNC_STAGES-1];
  assign hdr = lnk.rx_data_in[DATA_W-1 -: HDR_W];
  assign hdr_ok = hdr == HDR_PATTERN;
`ifdef GT_RX_AUTO_POLARITY_EN
  assign hdr_inv = hdr == ~HDR_PATTERN;
`else
  assign hdr_inv = 1'b0;
`endif
  assign err_inc = state == LOCKED && !hdr_ok;
  assign lnk.link_up = state == LOCKED;
  assign lnk.rx_polarity = pol_q;
  always_comb begin
    state_nxt = state;
    word_cnt_nxt = '0;
    wait_cnt_nxt = '0;
    match_cnt_nxt = '0;
    miss_cnt_nxt = '0;
    slip_nxt = 1'b0;
    pol_flip = 1'b0;
    lock_nxt = 1'b0;
    case (state)
      WAIT: state_nxt = lnk.rx_system_reset ? WAIT : HUNT;
      HUNT: begin
        state_nxt = hdr_ok ? VERIFY : (hdr_inv || word_cnt == WC_LAST) ? SLIP : HUNT;
        match_cnt_nxt = MC_W'(hdr_ok);
        word_cnt_nxt = word_cnt + 1'b1;
        slip_nxt = !hdr_ok && !hdr_inv && word_cnt == WC_LAST;
        pol_flip = !hdr_ok && hdr_inv;
      end
      SLIP: begin
        wait_cnt_nxt = wait_cnt + 1'b1;
        state_nxt = wait_cnt == SW_LAST ? HUNT : SLIP;
      end
      VERIFY: begin
        match_cnt_nxt = match_cnt + 1'b1;
        lock_nxt = hdr_ok && match_cnt == MC_LAST;
        state_nxt = !hdr_ok ? HUNT : lock_nxt ? LOCKED : VERIFY;
      end
      LOCKED: begin
        miss_cnt_nxt = hdr_ok ? '0 : miss_cnt + 1'b1;
        state_nxt = (!hdr_ok && miss_cnt == UC_LAST) ? HUNT : LOCKED;
      end
      default: state_nxt = WAIT;
    endcase
  end
  // A slip wraps the count after every bit offset has been tried
  always_ff @(posedge gt0_rxusrclk2_out or negedge gt0_rxresetdone_out)
    if (!gt0_rxresetdone_out) begin
      state <= WAIT;
      word_cnt <= '0;
      wait_cnt <= '0;
      match_cnt <= '0;
      miss_cnt <= '0;
      pol_q <= 1'b0;
      lnk.rx_slip <= 1'b0;
      lnk.slip_count <= '0;
      lnk.err_count <= '0;
      lnk.rx_data_out <= '0;
      lnk.rx_data_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      word_cnt <= word_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      match_cnt <= match_cnt_nxt;
      miss_cnt <= miss_cnt_nxt;
      pol_q <= pol_q ^ pol_flip;
      lnk.rx_slip <= slip_nxt;
      lnk.slip_count <= lock_nxt ? '0 : !slip_nxt ? lnk.slip_count :
                        lnk.slip_count == SC_LAST ? '0 : lnk.slip_count + 1'b1;
      lnk.err_count <= lnk.clear_err ? '0 :
                       (err_inc && !(&lnk.err_count)) ? lnk.err_count + 1'b1 : lnk.err_count;
      lnk.rx_data_out <= lnk.rx_data_in;
      lnk.rx_data_valid <= state == LOCKED && hdr_ok;
    end
endmodule
